// File: rtl/hsv_core_alu_stage.sv
// Execute-stage ALU: elastic valid/ready pipeline from issue to commit.
// Optional macro HSV_CORE_ALU_SKID_EN adds an output skid entry.

package hsv_core_alu_pkg;

    typedef enum logic [1:0] {
        BW_AND,
        BW_OR,
        BW_XOR,
        BW_PASS
    } alu_bitwise_t;

    typedef enum logic {
        OUT_ADDER,
        OUT_SHIFT
    } alu_out_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_increment;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] immediate;
        logic        illegal;
    } common_data_t;

    typedef struct packed {
        common_data_t common;
        logic         pc_relative;
        logic         is_immediate;
        logic         negate;
        logic         flip_signs;
        logic         sign_extend;
        logic         compare;
        alu_bitwise_t bitwise_select;
        alu_out_t     out_select;
    } alu_data_t;

    typedef struct packed {
        common_data_t common;
        logic         negate;
        logic         sign_extend;
        logic         compare;
        alu_bitwise_t bitwise_select;
        alu_out_t     out_select;
        logic [31:0]  a;
        logic [31:0]  b;
        logic [32:0]  sum;
    } alu_ex_t;

    typedef struct packed {
        common_data_t common;
        logic [31:0]  result;
        logic [31:0]  next_pc;
        logic         jump;
        logic         trap;
        logic         writeback;
    } commit_data_t;

    function automatic alu_ex_t alu_front(input alu_data_t d);
        alu_ex_t     e;
        logic [31:0] af;
        logic [31:0] bf;
        logic [32:0] add_a;
        logic [32:0] add_b;
        e = '0;
        e.common = d.common;
        e.negate = d.negate;
        e.sign_extend = d.sign_extend;
        e.compare = d.compare;
        e.bitwise_select = d.bitwise_select;
        e.out_select = d.out_select;
        e.a = d.pc_relative ? d.common.pc : d.common.rs1;
        e.b = d.is_immediate ? d.common.immediate : d.common.rs2;
        af = e.a;
        bf = e.b;
        if (d.flip_signs) begin
            af[31] = ~af[31];
            bf[31] = ~bf[31];
        end
        add_a = {1'b0, af};
        add_b = {1'b0, bf};
        if (d.negate) begin
            add_b = ~add_b + 33'd1;
        end
        e.sum = add_a + add_b;
        return e;
    endfunction

    function automatic commit_data_t alu_back(input alu_ex_t e);
        commit_data_t c;
        logic [31:0]  bw;
        logic [31:0]  sh;
        logic [4:0]   amt;
        amt = e.b[4:0];
        bw = '0;
        unique case (e.bitwise_select)
            BW_AND:  bw = e.a & e.b;
            BW_OR:   bw = e.a | e.b;
            BW_XOR:  bw = e.a ^ e.b;
            BW_PASS: bw = e.sum[31:0];
            default: bw = '0;
        endcase
        if (e.negate) begin
            sh = e.a << amt;
        end else if (e.sign_extend) begin
            sh = $signed(e.a) >>> amt;
        end else begin
            sh = e.a >> amt;
        end
        c = '0;
        c.common = e.common;
        if (e.compare) begin
            c.result = {31'b0, e.sum[32]};
        end else if (e.out_select == OUT_SHIFT) begin
            c.result = sh;
        end else begin
            c.result = bw;
        end
        c.next_pc = e.common.pc_increment;
        c.jump = 1'b0;
        c.trap = e.common.illegal;
        c.writeback = !e.common.illegal;
        return c;
    endfunction

endpackage

module hsv_core_alu_stage
    import hsv_core_alu_pkg::*;
#(
    parameter int unsigned Stages = 2
) (
    input  logic         clk_core,
    input  logic         rst_core,
    input  logic         flush_req,
    input  logic         in_valid,
    output logic         in_ready,
    input  alu_data_t    alu_data,
    output logic         out_valid,
    input  logic         out_ready,
    output commit_data_t commit_data
);

    logic         last_valid;
    commit_data_t last_q;
    logic         last_dn_ready;
    logic         last_ok;
    logic         last_src_valid;
    commit_data_t last_d;

    assign last_ok = !last_valid || last_dn_ready;

    generate
        if (Stages == 2) begin : g_two
            logic    s1_valid;
            alu_ex_t s1_q;

            assign in_ready = !s1_valid || last_ok;
            assign last_src_valid = s1_valid;
            assign last_d = alu_back(s1_q);

            // Stage 1: operand select and adder result
            always_ff @(posedge clk_core) begin
                if (rst_core) begin
                    s1_valid <= 1'b0;
                    s1_q <= '0;
                end else if (flush_req) begin
                    s1_valid <= 1'b0;
                end else if (in_ready) begin
                    s1_valid <= in_valid;
                    if (in_valid) begin
                        s1_q <= alu_front(alu_data);
                    end
                end
            end
        end else begin : g_one
            assign in_ready = last_ok;
            assign last_src_valid = in_valid;
            assign last_d = alu_back(alu_front(alu_data));
        end
    endgenerate

    // Last stage: registered commit record
    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            last_valid <= 1'b0;
            last_q <= '0;
        end else if (flush_req) begin
            last_valid <= 1'b0;
        end else if (last_ok) begin
            last_valid <= last_src_valid;
            if (last_src_valid) begin
                last_q <= last_d;
            end
        end
    end

`ifdef HSV_CORE_ALU_SKID_EN
    logic         skid_valid;
    commit_data_t skid_q;

    assign last_dn_ready = !skid_valid;
    assign out_valid = skid_valid || last_valid;
    assign commit_data = skid_valid ? skid_q : last_q;

    // Skid entry catches the last stage when commit stalls
    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            skid_valid <= 1'b0;
            skid_q <= '0;
        end else if (flush_req) begin
            skid_valid <= 1'b0;
        end else if (skid_valid) begin
            if (out_ready) begin
                skid_valid <= 1'b0;
            end
        end else if (last_valid && !out_ready) begin
            skid_valid <= 1'b1;
            skid_q <= last_q;
        end
    end
`else
    assign last_dn_ready = out_ready;
    assign out_valid = last_valid;
    assign commit_data = last_q;
`endif

endmodule

// File: tb/tb_hsv_core_alu_stage.sv
// Directed bench for hsv_core_alu_stage (default Stages=2).
// Vector table plus backpressure, flush and reset sequences.

module tb_hsv_core_alu_stage;
    import hsv_core_alu_pkg::*;

    logic         clk_core = 1'b0;
    logic         rst_core;
    logic         flush_req;
    logic         in_valid;
    logic         in_ready;
    alu_data_t    alu_data;
    logic         out_valid;
    logic         out_ready;
    commit_data_t commit_data;

    int total = 0;
    int passed = 0;

    hsv_core_alu_stage #(.Stages(2)) dut (
        .clk_core    (clk_core),
        .rst_core    (rst_core),
        .flush_req   (flush_req),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_data    (alu_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .commit_data (commit_data)
    );

    always #5 clk_core = ~clk_core;

    typedef struct {
        alu_data_t   op;
        logic [31:0] result;
        logic        trap;
        logic        wb;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic alu_data_t mk(
        input logic [31:0] rs1, input logic [31:0] rs2,
        input logic [31:0] imm, input logic [31:0] pc,
        input logic is_imm, input logic pc_rel, input logic neg,
        input logic flip, input logic sext, input logic cmp,
        input alu_bitwise_t bw, input alu_out_t os, input logic ill);
        alu_data_t d;
        d = '0;
        d.common.pc = pc;
        d.common.pc_increment = pc + 32'd4;
        d.common.rs1 = rs1;
        d.common.rs2 = rs2;
        d.common.immediate = imm;
        d.common.illegal = ill;
        d.pc_relative = pc_rel;
        d.is_immediate = is_imm;
        d.negate = neg;
        d.flip_signs = flip;
        d.sign_extend = sext;
        d.compare = cmp;
        d.bitwise_select = bw;
        d.out_select = os;
        return d;
    endfunction

    function automatic alu_data_t add_op(input logic [31:0] x,
                                         input logic [31:0] y);
        return mk(x, y, 0, 32'h200, 0, 0, 0, 0, 0, 0,
                  BW_PASS, OUT_ADDER, 0);
    endfunction

    // Stream n ADD ops (rs1=base+i, rs2=i) holding out_ready low for hold cycles
    task automatic stream(input int n, input int hold, input string tag,
                          output int first_out, output int last_out,
                          output int saw_full);
        int sent;
        int got;
        int bad_stall;
        logic prev_stall;
        logic [31:0] prev_res;
        sent = 0;
        got = 0;
        bad_stall = 0;
        prev_stall = 0;
        prev_res = '0;
        saw_full = 0;
        first_out = -1;
        last_out = -1;
        for (int cyc = 0; cyc < 60 && got < n; cyc++) begin
            @(negedge clk_core);
            out_ready = (cyc >= hold);
            in_valid = (sent < n);
            alu_data = add_op(32'd100 + 32'(sent), 32'(sent));
            #1;
            if (prev_stall && (!out_valid || commit_data.result !== prev_res))
                bad_stall++;
            if (in_valid && !in_ready) saw_full = 1;
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                chk({tag, "_order"}, commit_data.result,
                    32'd100 + 32'(2 * got));
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                got++;
            end
            prev_stall = out_valid && !out_ready;
            prev_res = commit_data.result;
        end
        @(negedge clk_core);
        in_valid = 0;
        chk({tag, "_count"}, 32'(got), 32'(n));
        chk({tag, "_stall_stable"}, 32'(bad_stall), 0);
    endtask

    vec_t vt[14];
    int   lat;
    int   f_out;
    int   l_out;
    int   full;
    int   seen;

    initial begin
        vt[0]  = '{mk(5, 7, 0, 32'h100, 0, 0, 0, 0, 0, 0, BW_PASS, OUT_ADDER, 0),
                   32'd12, 0, 1};
        vt[1]  = '{mk(32'hFFFF_FFFF, 1, 0, 32'h104, 0, 0, 1, 1, 0, 1, BW_PASS, OUT_ADDER, 0),
                   32'd1, 0, 1};
        vt[2]  = '{mk(32'hFFFF_FFFF, 1, 0, 32'h108, 0, 0, 1, 0, 0, 1, BW_PASS, OUT_ADDER, 0),
                   32'd0, 0, 1};
        vt[3]  = '{mk(32'h8000_0000, 0, 4, 32'h10C, 1, 0, 0, 0, 1, 0, BW_PASS, OUT_SHIFT, 0),
                   32'hF800_0000, 0, 1};
        vt[4]  = '{mk(32'h8000_0000, 0, 4, 32'h110, 1, 0, 1, 0, 0, 0, BW_PASS, OUT_SHIFT, 0),
                   32'h0000_0000, 0, 1};
        vt[5]  = '{mk(32'h8000_0000, 0, 4, 32'h114, 1, 0, 0, 0, 0, 0, BW_PASS, OUT_SHIFT, 0),
                   32'h0800_0000, 0, 1};
        vt[6]  = '{mk(5, 7, 0, 32'h118, 0, 0, 1, 0, 0, 0, BW_PASS, OUT_ADDER, 0),
                   32'hFFFF_FFFE, 0, 1};
        vt[7]  = '{mk(32'hF0F0, 32'hFF00, 0, 32'h11C, 0, 0, 0, 0, 0, 0, BW_AND, OUT_ADDER, 0),
                   32'hF000, 0, 1};
        vt[8]  = '{mk(32'hF0F0, 32'hFF00, 0, 32'h120, 0, 0, 0, 0, 0, 0, BW_OR, OUT_ADDER, 0),
                   32'hFFF0, 0, 1};
        vt[9]  = '{mk(32'hF0F0, 32'hFF00, 0, 32'h124, 0, 0, 0, 0, 0, 0, BW_XOR, OUT_ADDER, 0),
                   32'h0FF0, 0, 1};
        vt[10] = '{mk(9, 9, 32'h2000, 32'h1000, 1, 1, 0, 0, 0, 0, BW_PASS, OUT_ADDER, 0),
                   32'h3000, 0, 1};
        vt[11] = '{mk(1, 2, 0, 32'h4444, 0, 0, 0, 0, 0, 0, BW_PASS, OUT_ADDER, 1),
                   32'd3, 1, 0};
        vt[12] = '{mk(3, 3, 0, 32'h130, 0, 0, 1, 1, 0, 1, BW_PASS, OUT_ADDER, 0),
                   32'd0, 0, 1};
        vt[13] = '{mk(0, 32'hFFFF_FFFF, 0, 32'h134, 0, 0, 1, 0, 0, 1, BW_PASS, OUT_ADDER, 0),
                   32'd1, 0, 1};

        rst_core = 1;
        flush_req = 0;
        in_valid = 0;
        out_ready = 1;
        alu_data = '0;
        repeat (3) @(posedge clk_core);
        @(negedge clk_core);
        rst_core = 0;
        #1;
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_in_ready", 32'(in_ready), 1);
        chk("reset_commit_zero", 32'(commit_data == '0), 1);

        for (int i = 0; i < 14; i++) begin
            @(negedge clk_core);
            in_valid = 1;
            alu_data = vt[i].op;
            #1;
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 1);
            @(negedge clk_core);
            in_valid = 0;
            lat = 1;
            #1;
            while (!out_valid && lat < 8) begin
                @(negedge clk_core);
                lat++;
                #1;
            end
            chk($sformatf("v%0d_latency", i), 32'(lat), 2);
            chk($sformatf("v%0d_result", i), commit_data.result, vt[i].result);
            chk($sformatf("v%0d_trap", i), 32'(commit_data.trap), 32'(vt[i].trap));
            chk($sformatf("v%0d_writeback", i), 32'(commit_data.writeback),
                32'(vt[i].wb));
            chk($sformatf("v%0d_next_pc", i), commit_data.next_pc,
                vt[i].op.common.pc + 32'd4);
            chk($sformatf("v%0d_pc", i), commit_data.common.pc,
                vt[i].op.common.pc);
            chk($sformatf("v%0d_jump", i), 32'(commit_data.jump), 0);
        end

        stream(5, 4, "bp", f_out, l_out, full);
        chk("bp_in_ready_low_when_full", 32'(full), 1);

        stream(5, 0, "b2b", f_out, l_out, full);
        chk("b2b_no_bubbles", 32'(l_out - f_out), 4);
        chk("b2b_in_ready_high", 32'(full), 0);

        @(negedge clk_core);
        out_ready = 0;
        in_valid = 1;
        alu_data = add_op(32'hA, 1);
        @(negedge clk_core);
        alu_data = add_op(32'hB, 1);
        @(negedge clk_core);
        flush_req = 1;
        alu_data = add_op(32'hC, 1);
        @(negedge clk_core);
        flush_req = 0;
        in_valid = 0;
        #1;
        chk("flush_out_valid_next", 32'(out_valid), 0);
        out_ready = 1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_core);
            #1;
            if (out_valid) seen++;
        end
        chk("flush_nothing_emerges", 32'(seen), 0);
        chk("flush_in_ready_after", 32'(in_ready), 1);

        @(negedge clk_core);
        in_valid = 1;
        alu_data = add_op(32'd40, 32'd2);
        @(negedge clk_core);
        in_valid = 0;
        lat = 1;
        #1;
        while (!out_valid && lat < 8) begin
            @(negedge clk_core);
            lat++;
            #1;
        end
        chk("post_flush_latency", 32'(lat), 2);
        chk("post_flush_result", commit_data.result, 32'd42);

        @(negedge clk_core);
        out_ready = 0;
        in_valid = 1;
        alu_data = add_op(32'd7, 32'd8);
        @(negedge clk_core);
        in_valid = 0;
        @(negedge clk_core);
        rst_core = 1;
        @(negedge clk_core);
        rst_core = 0;
        #1;
        chk("rst_mid_out_valid", 32'(out_valid), 0);
        chk("rst_mid_commit_zero", 32'(commit_data == '0), 1);
        chk("rst_mid_in_ready", 32'(in_ready), 1);
        out_ready = 1;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_core);
            #1;
            if (out_valid) seen++;
        end
        chk("rst_mid_nothing_emerges", 32'(seen), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
